// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues one single-beat bus transaction per memory
// instruction, stalls the pipeline until it completes, and formats the writeback value.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_MEM,
   input  logic [31:0] AluOutM,
   input  logic [31:0] StoreDataM,
   input  logic [4:0]  RdM,
   input  logic [2:0]  RegWriteM,
   input  logic        MemToRegM,
   input  logic [3:0]  MemWriteM,
   input  logic        LoadNpcM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic        stall_mem,
   output logic [31:0] ResultM,
   output logic [4:0]  RdOut,
   output logic [2:0]  RegWriteOut,
   output logic        misalign,
   output logic        bus_timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t          state_r, state_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]     load_q_r;
   logic            mem_op_s, word_s, half_s, misalign_s, start_s, abort_s;

   // Extract the addressed byte/half from the read word and extend it to 32 bits.
   function automatic logic [31:0] fmt_load(input logic [2:0] kind, input logic [1:0] off,
                                            input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (kind)
         3'd1:    fmt_load = {{24{b[7]}}, b};
         3'd2:    fmt_load = {{16{h[15]}}, h};
         3'd4:    fmt_load = {24'd0, b};
         3'd5:    fmt_load = {16'd0, h};
         default: fmt_load = word;
      endcase
   endfunction

   // Access classification and alignment check.
   always_comb begin
      mem_op_s   = MemToRegM | (|MemWriteM);
      word_s     = (MemToRegM && (RegWriteM == 3'd3)) || (MemWriteM == 4'b1111);
      half_s     = (MemToRegM && ((RegWriteM == 3'd2) || (RegWriteM == 3'd5)))
                   || (MemWriteM == 4'b0011);
      misalign_s = mem_op_s && ((word_s && (AluOutM[1:0] != 2'b00)) || (half_s && AluOutM[0]));
      start_s    = mem_op_s && !misalign_s;
   end

   // Next-state and stall decode.
   always_comb begin
      state_next_s = state_r;
      stall_mem    = 1'b0;
      abort_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               stall_mem    = 1'b1;
               state_next_s = BUS;
            end else begin
               state_next_s = IDLE;
            end
         end
         BUS: begin
            stall_mem = 1'b1;
            if (bus_ready) begin
               state_next_s = DONE;
            end else if (cnt_r == CNT_LAST) begin
               state_next_s = DONE;
               abort_s      = 1'b1;
            end else begin
               state_next_s = BUS;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State, bus request registers, timeout counter and captured load data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= 32'd0;
         bus_wdata   <= 32'd0;
         bus_wstrb   <= 4'd0;
         load_q_r    <= 32'd0;
         cnt_r       <= '0;
         bus_timeout <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         bus_timeout <= abort_s;
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  bus_req   <= 1'b1;
                  bus_we    <= |MemWriteM;
                  bus_addr  <= {AluOutM[31:2], 2'b00};
                  bus_wdata <= StoreDataM << {AluOutM[1:0], 3'b000};
                  bus_wstrb <= MemWriteM << AluOutM[1:0];
                  cnt_r     <= '0;
               end
            end
            BUS: begin
               if (bus_ready) begin
                  bus_req  <= 1'b0;
                  load_q_r <= fmt_load(RegWriteM, AluOutM[1:0], bus_rdata);
               end else if (cnt_r == CNT_LAST) begin
                  bus_req  <= 1'b0;
                  load_q_r <= 32'd0;
               end else begin
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            default: ;
         endcase
      end
   end

   // Writeback formatting; a timed-out access only reports through DONE.
   always_comb begin
      if (MemToRegM) begin
         ResultM = load_q_r;
      end else if (LoadNpcM) begin
         ResultM = PC_MEM + 32'd4;
      end else begin
         ResultM = AluOutM;
      end
      if (misalign_s || ((state_r == DONE) && bus_timeout)) begin
         RegWriteOut = 3'd0;
      end else begin
         RegWriteOut = RegWriteM;
      end
      RdOut    = RdM;
      misalign = misalign_s;
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: pipeline driver, bus responder and
// retire monitor, all checked against a byte/word arithmetic reference model.
module tb_mem_access_stage;

   localparam int T = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PC_MEM, AluOutM, StoreDataM;
   logic [4:0]  RdM;
   logic [2:0]  RegWriteM;
   logic        MemToRegM, LoadNpcM;
   logic [3:0]  MemWriteM;
   logic        bus_req, bus_we, bus_ready, stall_mem, misalign, bus_timeout;
   logic [31:0] bus_addr, bus_wdata, bus_rdata, ResultM;
   logic [3:0]  bus_wstrb;
   logic [4:0]  RdOut;
   logic [2:0]  RegWriteOut;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .PC_MEM(PC_MEM), .AluOutM(AluOutM), .StoreDataM(StoreDataM),
      .RdM(RdM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
      .LoadNpcM(LoadNpcM), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
      .bus_rdata(bus_rdata), .stall_mem(stall_mem), .ResultM(ResultM), .RdOut(RdOut),
      .RegWriteOut(RegWriteOut), .misalign(misalign), .bus_timeout(bus_timeout)
   );

   typedef struct {
      logic [31:0] result;
      logic        chk_res;
      logic [2:0]  rw;
      logic [4:0]  rd;
      logic        mis;
      logic        tmo;
      int          stall;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          delay;
      logic [31:0] rdata;
   } bus_t;

   exp_t exp_q[$];
   bus_t bus_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] load_model(input logic [2:0] rw, input logic [31:0] addr,
                                              input logic [31:0] word);
      longint w, lane, b, h, v;
      w    = longint'(word);
      lane = longint'(addr % 32'd4);
      b    = (w >> (8 * lane)) % 256;
      h    = (w >> (16 * (lane / 2))) % 65536;
      case (rw)
         3'd1:    v = (b >= 128) ? b - 256 : b;
         3'd2:    v = (h >= 32768) ? h - 65536 : h;
         3'd4:    v = b;
         3'd5:    v = h;
         default: v = w;
      endcase
      return 32'(v);
   endfunction

   task automatic set_nop();
      PC_MEM = 32'd0; AluOutM = 32'd0; StoreDataM = 32'd0; RdM = 5'd0;
      RegWriteM = 3'd0; MemToRegM = 1'b0; MemWriteM = 4'd0; LoadNpcM = 1'b0;
   endtask

   // Present one instruction, queue its expectations, hold it until it retires.
   task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input logic [2:0] rw, input logic m2r,
                        input logic [3:0] mw, input logic npc, input int delay,
                        input logic [31:0] rdata);
      exp_t e;
      bus_t b;
      int   size, lane;
      logic memop, s, done;
      lane  = int'(alu % 32'd4);
      memop = m2r || (mw != 4'd0);
      if (m2r) size = (rw == 3'd1 || rw == 3'd4) ? 1 : (rw == 3'd2 || rw == 3'd5) ? 2 : 4;
      else     size = $countones(mw);
      e.mis   = memop && ((size == 4 && lane != 0) || (size == 2 && lane % 2 != 0));
      e.tmo   = memop && !e.mis && delay >= T;
      e.stall = (!memop || e.mis) ? 0 : (e.tmo ? T + 1 : delay + 2);
      e.rw    = (e.mis || e.tmo) ? 3'd0 : rw;
      e.rd    = rd;
      e.chk_res = !(m2r && e.mis);
      if (m2r)      e.result = e.tmo ? 32'd0 : load_model(rw, alu, rdata);
      else if (npc) e.result = 32'((longint'(pc) + 4) % 64'h1_0000_0000);
      else          e.result = alu;
      if (memop && !e.mis) begin
         b.we    = (mw != 4'd0);
         b.addr  = alu - 32'(lane);
         b.wdata = 32'(longint'(sd) << (8 * lane));
         b.wstrb = 4'(int'(mw) << lane);
         b.delay = delay;
         b.rdata = rdata;
         bus_q.push_back(b);
      end
      PC_MEM = pc; AluOutM = alu; StoreDataM = sd; RdM = rd; RegWriteM = rw;
      MemToRegM = m2r; MemWriteM = mw; LoadNpcM = npc;
      exp_q.push_back(e);
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         s = stall_mem;
         @(posedge clk);
         #1;
         done = !s;
      end
      if (!done) begin
         errors++;
         $display("FAIL retire_timeout: instruction at addr %h never retired", alu);
      end
   endtask

   // Bus responder: checks each request cycle and answers after the planned delay.
   initial begin
      bus_t cur;
      int   wcnt;
      logic active;
      active = 1'b0; wcnt = 0; bus_ready = 1'b0; bus_rdata = 32'd0;
      cur = '{1'b0, 32'd0, 32'd0, 4'd0, 0, 32'd0};
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 1'b0; wcnt = 0; bus_ready = 1'b0;
         end else if (bus_req) begin
            if (!active) begin
               if (bus_q.size() == 0) begin
                  errors++;
                  $display("FAIL bus_unexpected: request to %h with nothing planned", bus_addr);
                  cur = '{bus_we, bus_addr, bus_wdata, bus_wstrb, 0, 32'd0};
               end else begin
                  cur = bus_q.pop_front();
               end
               active = 1'b1;
               wcnt = 0;
            end
            check("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
            check("bus_addr", bus_addr, cur.addr);
            if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
            check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, cur.wstrb});
            bus_ready = (wcnt == cur.delay);
            bus_rdata = (wcnt == cur.delay) ? cur.rdata : $urandom;
            wcnt++;
         end else begin
            active = 1'b0;
            bus_ready = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
         end
      end
   end

   // Retire monitor: compares the writeback side whenever the stage releases.
   initial begin
      exp_t e;
      int   stall_cnt;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_cnt = 0;
         end else if (stall_mem) begin
            stall_cnt++;
            check("timeout_while_stalled", {31'd0, bus_timeout}, 32'd0);
         end else begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               if (e.chk_res) check("ResultM", ResultM, e.result);
               check("RegWriteOut", {29'd0, RegWriteOut}, {29'd0, e.rw});
               check("RdOut", {27'd0, RdOut}, {27'd0, e.rd});
               check("misalign", {31'd0, misalign}, {31'd0, e.mis});
               check("bus_timeout", {31'd0, bus_timeout}, {31'd0, e.tmo});
               check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
               check("bus_req_at_retire", {31'd0, bus_req}, 32'd0);
            end
            stall_cnt = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind;
      logic [31:0] alu;
      logic [3:0]  mw;
      rst = 1'b1;
      set_nop();
      repeat (3) @(posedge clk);
      #1;
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_bus_we", {31'd0, bus_we}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
      check("rst_bus_timeout", {31'd0, bus_timeout}, 32'd0);
      check("rst_stall", {31'd0, stall_mem}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue(32'h0, 32'h1000, 32'hCAFEBABE, 5'd0, 3'd0, 1'b0, 4'b1111, 1'b0, 0, 32'h0);
      issue(32'h0, 32'h2003, 32'h0, 5'd3, 3'd1, 1'b1, 4'b0000, 1'b0, 0, 32'h80123456);
      issue(32'h0, 32'h2003, 32'h0, 5'd4, 3'd4, 1'b1, 4'b0000, 1'b0, 2, 32'h80123456);
      issue(32'h0, 32'h0002, 32'h1234, 5'd0, 3'd0, 1'b0, 4'b0011, 1'b0, 1, 32'h0);
      issue(32'h0, 32'h0001, 32'h0, 5'd5, 3'd2, 1'b1, 4'b0000, 1'b0, 0, 32'h0);
      issue(32'h0, 32'h3000, 32'h0, 5'd6, 3'd3, 1'b1, 4'b0000, 1'b0, T - 1, 32'h600DF00D);
      issue(32'h0, 32'h3004, 32'h0, 5'd7, 3'd3, 1'b1, 4'b0000, 1'b0, T, 32'h0BADBAD0);
      issue(32'h100, 32'h55, 32'h0, 5'd1, 3'd3, 1'b0, 4'b0000, 1'b1, 0, 32'h0);
      issue(32'hFFFFFFFC, 32'h55, 32'h0, 5'd1, 3'd3, 1'b0, 4'b0000, 1'b1, 0, 32'h0);
      issue(32'h0, 32'h4002, 32'h0, 5'd8, 3'd5, 1'b1, 4'b0000, 1'b0, 0, 32'hFEDC1234);

      // Reset in the middle of a load; the abandoned access must not reappear.
      PC_MEM = 32'h0; AluOutM = 32'h5000; RdM = 5'd9; RegWriteM = 3'd3; MemToRegM = 1'b1;
      MemWriteM = 4'd0; LoadNpcM = 1'b0; StoreDataM = 32'd0;
      bus_q.push_back('{1'b0, 32'h5000, 32'h0, 4'd0, 1000, 32'h0});
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      set_nop();
      #1;
      bus_q.delete();
      exp_q.delete();
      check("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("async_rst_stall", {31'd0, stall_mem}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue(32'h0, 32'h6000, 32'h0, 5'd10, 3'd3, 1'b1, 4'b0000, 1'b0, 1, 32'h13579BDF);

      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 9);
         alu  = $urandom;
         if ($urandom_range(0, 1) == 1) alu = alu - (alu % 32'd4);
         mw   = (kind == 7) ? 4'b0001 : (kind == 8) ? 4'b0011 : (kind == 9) ? 4'b1111 : 4'b0000;
         if (kind <= 1)
            issue($urandom, alu, $urandom, 5'($urandom), 3'($urandom), 1'b0, 4'd0,
                  1'(kind), 0, 32'h0);
         else if (kind <= 6)
            issue($urandom, alu, $urandom, 5'($urandom), 3'(kind - 1), 1'b1, 4'd0,
                  1'($urandom_range(0, 1)), $urandom_range(0, T + 1), $urandom);
         else
            issue($urandom, alu, $urandom, 5'($urandom), 3'd0, 1'b0, mw, 1'b0,
                  $urandom_range(0, T + 1), 32'h0);
      end

      set_nop();
      repeat (4) @(posedge clk);
      #1;
      check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
      check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage load/store unit directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs and runs one single-beat transaction per memory instruction on a ready-handshaked data bus.
- Stalls the pipeline until the access completes, then formats the result for the MEM/WB register.
- Handles byte-lane alignment, load sign/zero extension, misalignment detection and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in BUS waiting for bus_ready before abort.
- CNT_W, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- PC_MEM  in  32  PC of the instruction in MEM.
- AluOutM  in  32  effective address or ALU result.
- StoreDataM  in  32  store data, LSB-justified.
- RdM  in  5  destination register.
- RegWriteM  in  3  write type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; any nonzero value means full-word write when MemToRegM=0.
- MemToRegM  in  1  instruction is a load.
- MemWriteM  in  4  store byte mask, LSB-justified: 0001 SB, 0011 SH, 1111 SW.
- LoadNpcM  in  1  result is PC_MEM+4 (JAL/JALR).
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, AluOutM with bits [1:0] cleared.
- bus_wdata  out  32  lane-shifted store data.
- bus_wstrb  out  4  lane-shifted byte mask.
- bus_ready  in  1  transaction complete; rdata valid the same cycle.
- bus_rdata  in  32  read word.
- stall_mem  out  1  hold pipeline (drives EX/MEM en low and stalls upstream).
- ResultM  out  32  writeback value to MEM/WB.
- RdOut  out  5  RdM pass-through.
- RegWriteOut  out  3  RegWriteM, forced to 0 on misaligned load or timeout.
- misalign  out  1  misaligned access flag (combinational).
- bus_timeout  out  1  one-cycle pulse on abort.

Behaviour:
- mem_op = MemToRegM | (|MemWriteM).
- Misaligned when mem_op and any of:
  - word access (LW or mask 1111) with addr[1:0]≠0;
  - half access (LH/LHU or mask 0011) with addr[0]≠0.
- Misaligned op: no bus access, stall_mem=0, store suppressed, RegWriteOut=0, misalign=1.
- FSM states IDLE, BUS, DONE. Reset and every abort return to IDLE.
- IDLE:
  - Aligned mem_op → stall_mem=1; next edge: bus_req←1, bus_we←|MemWriteM, bus_addr, bus_wdata←StoreDataM<<(8*addr[1:0]), bus_wstrb←MemWriteM<<addr[1:0]; timeout counter←0; go to BUS.
  - Otherwise stall_mem=0.
- BUS:
  - stall_mem=1. Bus outputs held stable while bus_req=1.
  - bus_ready=1 → capture formatted load data into load_q; bus_req←0; go to DONE.
  - Else counter increments. Counter reaching TIMEOUT_CYCLES-1 without ready → bus_req←0, load_q←0, bus_timeout pulses the following cycle, go to DONE with RegWriteOut forced 0.
- DONE:
  - stall_mem=0 for exactly one cycle, so EX/MEM and MEM/WB advance on this edge.
  - ResultM valid. Next state IDLE.
- Minimum memory-op latency is 3 cycles (IDLE, BUS with immediate ready, DONE); each wait cycle in BUS adds 1.
- Back-to-back memory ops: the DONE edge loads the next instruction; IDLE then restarts. The same instruction is never issued twice.
- Load formatting:
  - Byte lane = addr[1:0], half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- ResultM (combinational):
  - MemToRegM → load_q;
  - else LoadNpcM → PC_MEM+4, mod 2^32;
  - else AluOutM.
- Non-memory instructions pass through with zero added latency.
- bus_ready outside BUS is ignored.
- Reset (async, any state, including mid-transaction):
  - State=IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, load_q, counter and bus_timeout all 0.
  - An abandoned transaction is not retried.
  - After reset, stall_mem follows IDLE rules.

Test Plan:
- SW: AluOutM=0x1000, StoreDataM=0xCAFEBABE, MemWriteM=1111, ready on first BUS cycle → bus_we=1, addr 0x1000, wstrb 1111; stall_mem high 2 cycles then low 1.
- LB: addr 0x2003, rdata=0x80xxxxxx → ResultM=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH: addr 0x0002, StoreDataM=0x1234 → wstrb 1100, wdata 0x12340000. LH at 0x0001 → misalign=1, bus_req stays 0, RegWriteOut=0, no stall.
- Ready delayed 5 cycles → stall_mem high 7 cycles. With TIMEOUT_CYCLES=4 and no ready → bus_timeout pulses once, RegWriteOut=0, return to IDLE.
- JAL: PC_MEM=0x100, LoadNpcM=1 → ResultM=0x104, no stall. PC_MEM=0xFFFFFFFC → ResultM=0x00000000 (wraps).
- rst asserted in BUS → bus_req drops immediately (async); after release a new load issues normally.
